// File: rtl/comparator_4bit_if.sv
// comparator_4bit_if: operand/flag bundle between a compare requester and the comparator
interface comparator_4bit_if #(parameter int WIDTH = 4);
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             A_greater;
  logic             A_equal;
  logic             A_less;
  logic             out_valid;
  modport master (output in_valid, A, B, input A_greater, A_equal, A_less, out_valid);
  modport slave (input in_valid, A, B, output A_greater, A_equal, A_less, out_valid);
endinterface

// File: rtl/comparator_4bit.sv
// comparator_4bit: registered magnitude comparator producing one-hot greater/equal/less flags
module comparator_4bit #(
  parameter int WIDTH = 4,
  parameter bit SIGNED = 1'b0
) (
  input logic clk,
  input logic rst,
  comparator_4bit_if.slave bus
);
  logic gt, eq, lt;
  // combinational compare; equality is bitwise so it ignores SIGNED
  always_comb begin
    eq = bus.A == bus.B;
    gt = SIGNED ? ($signed(bus.A) > $signed(bus.B)) : (bus.A > bus.B);
    lt = !gt && !eq;
  end
  // register flags on accepted pairs, hold them on idle cycles, clear on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.A_greater <= 1'b0;
      bus.A_equal   <= 1'b0;
      bus.A_less    <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.A_greater <= gt;
        bus.A_equal   <= eq;
        bus.A_less    <= lt;
      end
    end
  end
endmodule

// File: tb/tb_comparator_4bit.sv
// tb_comparator_4bit: directed and random checks of unsigned and signed comparators against a numeric model
module tb_comparator_4bit;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  logic exp_g[2], exp_e[2], exp_l[2], exp_v[2];
  always #5 clk = ~clk;
  comparator_4bit_if #(.WIDTH(4)) u_if ();
  comparator_4bit_if #(.WIDTH(4)) s_if ();
  comparator_4bit #(.WIDTH(4), .SIGNED(1'b0)) dut_u (.clk(clk), .rst(rst), .bus(u_if.slave));
  comparator_4bit #(.WIDTH(4), .SIGNED(1'b1)) dut_s (.clk(clk), .rst(rst), .bus(s_if.slave));
  function automatic int val(logic [3:0] x, int s);
    return (s == 1 && x >= 4'd8) ? int'(x) - 16 : int'(x);
  endfunction
  task automatic chk(string tag, logic obs, logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask
  task automatic step(logic r, logic v, logic [3:0] a, logic [3:0] b);
    rst = r;
    u_if.in_valid = v; u_if.A = a; u_if.B = b;
    s_if.in_valid = v; s_if.A = a; s_if.B = b;
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (r) begin
        exp_g[m] = 0; exp_e[m] = 0; exp_l[m] = 0; exp_v[m] = 0;
      end else begin
        exp_v[m] = v;
        if (v) begin
          exp_g[m] = val(a, m) > val(b, m);
          exp_e[m] = val(a, m) == val(b, m);
          exp_l[m] = val(a, m) < val(b, m);
        end
      end
    end
    #1;
    chk("u_gt", u_if.A_greater, exp_g[0]);
    chk("u_eq", u_if.A_equal, exp_e[0]);
    chk("u_lt", u_if.A_less, exp_l[0]);
    chk("u_ov", u_if.out_valid, exp_v[0]);
    chk("s_gt", s_if.A_greater, exp_g[1]);
    chk("s_eq", s_if.A_equal, exp_e[1]);
    chk("s_lt", s_if.A_less, exp_l[1]);
    chk("s_ov", s_if.out_valid, exp_v[1]);
  endtask
  initial begin
    step(1, 1, 4'd5, 4'd3);
    step(1, 1, 4'd5, 4'd3);
    step(0, 0, 4'd5, 4'd3);
    chk("rst_all_zero", u_if.A_greater | u_if.A_equal | u_if.A_less | u_if.out_valid, 1'b0);
    step(0, 1, 4'b0101, 4'b0011); chk("dir0_gt", u_if.A_greater, 1'b1);
    step(0, 1, 4'b1001, 4'b1001); chk("dir1_eq", u_if.A_equal, 1'b1);
    step(0, 1, 4'b0001, 4'b1010); chk("dir2_lt", u_if.A_less, 1'b1);
    step(0, 1, 4'b1100, 4'b0111); chk("dir3_gt", u_if.A_greater, 1'b1);
    step(0, 1, 4'b0011, 4'b0101); chk("dir4_lt", u_if.A_less, 1'b1);
    chk("dir4_ov", u_if.out_valid, 1'b1);
    step(0, 1, 4'd12, 4'd7);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 4'd0, 4'd15);
      chk("hold_gt", u_if.A_greater, 1'b1);
      chk("hold_ov", u_if.out_valid, 1'b0);
    end
    step(0, 1, 4'd0, 4'd0);   chk("b00_eq", u_if.A_equal, 1'b1);
    step(0, 1, 4'd15, 4'd0);  chk("b150_gt", u_if.A_greater, 1'b1);
    step(0, 1, 4'd0, 4'd15);  chk("b015_lt", u_if.A_less, 1'b1);
    step(0, 1, 4'd15, 4'd15); chk("b1515_eq", u_if.A_equal, 1'b1);
    step(0, 1, 4'b1000, 4'b0111); chk("sgn_m8_p7_lt", s_if.A_less, 1'b1);
    step(0, 1, 4'b1111, 4'b1110); chk("sgn_m1_m2_gt", s_if.A_greater, 1'b1);
    step(0, 1, 4'b0000, 4'b1111); chk("sgn_0_m1_gt", s_if.A_greater, 1'b1);
    step(0, 1, 4'd1, 4'd10);
    step(1, 0, 4'd1, 4'd10);
    chk("mid_rst_zero", u_if.A_greater | u_if.A_equal | u_if.A_less | u_if.out_valid, 1'b0);
    step(0, 0, 4'd1, 4'd10);
    chk("mid_rst_no_lt", u_if.A_less & u_if.out_valid, 1'b0);
    for (int i = 0; i < 300; i++)
      step(logic'($urandom_range(0, 19) == 0), logic'($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
